// File: rtl/inst_encoder.sv
// RV32I instruction assembler for I/S/B formats with a one-deep registered output,
// auto-incrementing write address and a saturating count of rejected bundles.
module inst_encoder #(
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned BaseAddr  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_type,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [Width-1:0]     in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width-1:0]     out_inst,
  output logic [AddrWidth-1:0] out_addr,
  output logic                 err,
  output logic [7:0]           err_count
);

  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [1:0] TypeI  = 2'd0;
  localparam logic [1:0] TypeS  = 2'd1;
  localparam logic [1:0] TypeB  = 2'd2;
  localparam logic [7:0] ErrMax = 8'hFF;

  logic             accept;
  logic             complete;
  logic             legal;
  logic [Width-1:0] enc;

  // Restart blocks acceptance so a bundle offered alongside it is never consumed.
  assign in_ready = !restart && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;

  // Field packing and range check; an immediate is legal when its upper bits are pure sign.
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (in_type)
      TypeI: begin
        legal = (&in_imm[Width-1:11]) || !(|in_imm[Width-1:11]);
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpI};
      end
      TypeS: begin
        legal = (&in_imm[Width-1:11]) || !(|in_imm[Width-1:11]);
        enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OpS};
      end
      TypeB: begin
        legal = ((&in_imm[Width-1:12]) || !(|in_imm[Width-1:12])) && !in_imm[0];
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OpB};
      end
      default: begin
        legal = 1'b0;
        enc   = '0;
      end
    endcase
  end

  // Output register, address counter and error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= AddrWidth'(BaseAddr);
      err       <= 1'b0;
      err_count <= '0;
    end else if (restart) begin
      out_valid <= 1'b0;
      out_addr  <= AddrWidth'(BaseAddr);
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && (err_count != ErrMax)) begin
        err_count <= err_count + 8'd1;
      end
      if (complete) begin
        out_addr <= out_addr + AddrWidth'(1);
      end
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_inst  <= enc;
      end else if (complete) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized scoreboard bench for inst_encoder: driver predicts words from field
// arithmetic, a monitor pops and compares on each completed output handshake.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  // Second instance with a narrow counter for the wrap check.
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_imm = '0;
  logic        w_out_valid;
  logic [31:0] w_out_inst;
  logic [1:0]  w_out_addr;
  logic        w_err;
  logic [7:0]  w_err_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  addr;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  bit   mv = 0;
  bit   eerr = 0;
  int   cnt = 0;
  int   n = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  inst_encoder #(.AddrWidth(2), .BaseAddr(2)) dut_w (
    .clk(clk), .rst(rst), .restart(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_type(2'd0), .in_rd(5'd3), .in_rs1(5'd4), .in_rs2(5'd0),
    .in_funct3(3'd0), .in_imm(w_in_imm), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_inst(w_out_inst), .out_addr(w_out_addr), .err(w_err), .err_count(w_err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [1:0] t, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] u);
    logic [31:0] mid;
    mid = (32'(rs1) << 15) | (32'(f3) << 12);
    case (t)
      2'd0: return ((u & 32'hFFF) << 20) | mid | (32'(rd) << 7) | 32'h13;
      2'd1: return (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | mid
                   | ((u & 32'h1F) << 7) | 32'h23;
      2'd2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20) | mid | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 32'h1) << 7) | 32'h63;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] t, input logic [31:0] u);
    int s;
    s = u;
    case (t)
      2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
      2'd2:       return (s >= -4096) && (s <= 4094) && ((s & 1) == 0);
      default:    return 1'b0;
    endcase
  endfunction

  // Reference immediate generator, used to confirm every emitted word round-trips.
  function automatic logic [31:0] imm_gen(input logic [31:0] w);
    case (w[6:0])
      7'h13:   return {{20{w[31]}}, w[31:20]};
      7'h23:   return {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Called at negedge+1; checks the state left by the following posedge.
  task automatic step(input bit v, input logic [1:0] t, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [31:0] imm, input bit ordy, input bit rs,
      input bit use_g = 1'b0, input logic [31:0] g = 32'h0);
    bit   rdy, acc, lg;
    exp_t e;
    in_valid = v; in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm; out_ready = ordy; restart = rs;
    #1;
    rdy = !rs && (!mv || ordy);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    #2;
    acc = v && rdy;
    if (rs) begin
      q.delete(); n = 0; mv = 0; cnt = 0; eerr = 0;
    end else begin
      lg   = model_legal(t, imm);
      eerr = acc && !lg;
      if (eerr && cnt < 255) cnt++;
      if (acc && lg) begin
        e.inst = use_g ? g : model_enc(t, rd, rs1, rs2, f3, imm);
        e.addr = 8'(n);
        e.imm  = imm;
        q.push_back(e);
        n++;
        mv = 1;
      end else if (mv && ordy) begin
        mv = 0;
      end
    end
    @(negedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("err", 32'(err), 32'(eerr));
    chk("err_count", 32'(err_count), 32'(cnt));
    if (!mv) chk("addr_idle", 32'(out_addr), 32'(8'(n)));
  endtask

  task automatic rand_step(input bit rs_en);
    logic [1:0]  t;
    logic [31:0] imm;
    int          r;
    int          bnd[8] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095};
    r = $urandom % 16;
    t = (r == 0) ? 2'd3 : 2'(r % 3);
    case ($urandom % 8)
      0:       imm = $urandom;
      1:       imm = bnd[$urandom % 8];
      default: imm = int'($urandom_range(0, 8191)) - 4096;
    endcase
    step(($urandom % 4) != 0, t, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
         imm, ($urandom % 3) != 0, rs_en && (($urandom % 60) == 0));
  endtask

  // Monitor: compares the held word against the scoreboard head, pops on completion.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!rst && !restart && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_word", out_inst, 32'hxxxx_xxxx);
        end else begin
          chk("out_inst", out_inst, q[0].inst);
          chk("out_addr", 32'(out_addr), 32'(q[0].addr));
          chk("imm_roundtrip", imm_gen(out_inst), q[0].imm);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", 32'(out_addr), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_w_addr", 32'(w_out_addr), 32'h2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Wrap: narrow counter starting at 2 must read 2,3,0,1 at full rate.
    w_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w_in_imm = 32'(k * 4);
      @(negedge clk); #1;
      chk("w_valid", 32'(w_out_valid), 32'h1);
      chk("w_addr", 32'(w_out_addr), 32'((2 + k) % 4));
      chk("w_inst", w_out_inst, model_enc(2'd0, 5'd3, 5'd4, 5'd0, 3'd0, 32'(k * 4)));
    end
    w_in_valid = 1'b0;

    // Known words from hand assembly.
    step(1, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1, 0, 1, 32'h0050_0093);
    step(1, 2'd1, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1, 0, 1, 32'h0020_A423);
    step(1, 2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4, 1, 0, 1, 32'hFE20_8EE3);
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);

    // Three rejected bundles back to back.
    step(1, 2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 1, 0);
    step(1, 2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1, 0);
    step(1, 2'd3, 5'd1, 5'd1, 5'd2, 3'd0, 32'd0, 1, 0);
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);

    // Streaming with a three-cycle stall in the middle.
    for (int i = 0; i < 9; i++) begin
      step(1, 2'(i % 3), 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 32'(i * 2), !(i >= 2 && i <= 4), 0);
    end
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);

    // Restart with a stalled word and two errors pending.
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 1);
    step(1, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);
    step(1, 2'd1, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2049, 1, 0);
    step(1, 2'd0, 5'd7, 5'd8, 5'd0, 3'd1, 32'd100, 0, 0);
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 0, 0);
    step(1, 2'd0, 5'd7, 5'd8, 5'd0, 3'd1, 32'd5, 0, 1);
    step(0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) step(1, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 0);

    repeat (3000) rand_step(1'b1);

    // Asynchronous reset mid-cycle with a stalled word held.
    step(1, 2'd0, 5'd2, 5'd3, 5'd0, 3'd0, 32'd9, 0, 0);
    step(1, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_inst", out_inst, 32'h0);
    chk("arst_addr", 32'(out_addr), 32'h0);
    chk("arst_err_count", 32'(err_count), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); n = 0; mv = 0; cnt = 0; eerr = 0;
    #1;
    repeat (200) rand_step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
